load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter READ_LATENCY, default 1, gives the clock edges from the data_read_valid sample to a valid data_read; legal range 1..4.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on rising edge.
REQ-003 Port reset_n, input, 1, asynchronous active-low reset.
REQ-004 Port req_valid, input, 1, the core presents a load/store request.
REQ-005 Port req_ready, output, 1, the unit accepts a request this cycle.
REQ-006 Port req_we, input, 1, selects store when 1 and load when 0.
REQ-007 Port req_funct3, input, 3, RV32I width code: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu.
REQ-008 Port req_addr, input, 32, the byte address.
REQ-009 Port req_wdata, input, 32, the store data in low-aligned form.
REQ-010 Port resp_valid, output, 1, a response is available.
REQ-011 Port resp_ready, input, 1, the core consumes the response.
REQ-012 Port resp_rdata, output, 32, the extended load result; 0 for stores and errors.
REQ-013 Port resp_err, output, 1, flags a misaligned access or an illegal funct3.
REQ-014 Port data_addr, output, 32, the memory byte address.
REQ-015 Port data_write, output, 32, the lane-positioned store data.
REQ-016 Port data_write_byte, output, 4, the per-lane write enables.
REQ-017 Port data_read_valid, output, 1, the memory read strobe.
REQ-018 Port data_write_valid, output, 1, the memory write strobe.
REQ-019 Port data_read, input, 32, the memory read word, with lane 0 at bits 7:0.

Function
REQ-020 The FSM SHALL have four states: IDLE, ACCESS, WAIT, DONE.
REQ-021 In IDLE, req_ready SHALL be 1 and req_ready SHALL be 0 in every other state.
REQ-022 In IDLE, a request SHALL be accepted when req_valid is 1; the unit SHALL latch req_we, req_funct3, req_addr and req_wdata.
REQ-023 A halfword access with addr[0]=1, a word access with addr[1:0]!=0, a funct3 value of 3, 6 or 7, or a store with funct3 above 2 SHALL be an error that goes IDLE->DONE with resp_err=1 and no memory strobe.
REQ-024 A legal request SHALL go IDLE->ACCESS.
REQ-025 In ACCESS, the unit SHALL drive data_addr for exactly one cycle together with exactly one of data_write_valid (store) or data_read_valid (load).
REQ-026 ACCESS SHALL go to DONE for a store and to WAIT for a load.
REQ-027 WAIT SHALL count READ_LATENCY-1 further cycles, sample data_read on the last one, and then go to DONE.
REQ-028 Store lanes: sb SHALL drive {4{wdata[7:0]}} with enable 4'b0001<<addr[1:0]; sh SHALL drive {2{wdata[15:0]}} with enable 4'b0011<<(2*addr[1]); sw SHALL drive wdata with enable 4'b1111.
REQ-029 Load extraction SHALL shift data_read right by 8*addr[1:0].
REQ-030 lb and lh SHALL sign-extend from bit 7 and bit 15 respectively.
REQ-031 lbu and lhu SHALL zero-extend.
REQ-032 lw SHALL pass the word unchanged.
REQ-033 In DONE, resp_valid SHALL be 1 and resp_rdata and resp_err SHALL be held stable until resp_ready=1.
REQ-034 When resp_ready=1 in DONE, the unit SHALL go to IDLE.
REQ-035 A request SHALL NOT be accepted in the same cycle as a DONE->IDLE transition, giving a minimum of 3 cycles per store.
REQ-036 Outside ACCESS, data_read_valid, data_write_valid and data_write_byte SHALL be 0.
REQ-037 Outside ACCESS, data_addr SHALL hold the last latched address.
REQ-038 Load latency SHALL be 2+READ_LATENCY cycles from acceptance to resp_valid.
REQ-039 Store latency SHALL be 2 cycles from acceptance to resp_valid.
REQ-040 Error latency SHALL be 1 cycle from acceptance to resp_valid.

Reset
REQ-041 While reset_n=0, the state SHALL be IDLE, the WAIT counter SHALL be 0, and all outputs SHALL be 0 except req_ready=1.
REQ-042 A reset during ACCESS or WAIT SHALL abandon the transaction with no response, and strobes SHALL drop immediately on reset assertion.
REQ-043 After reset deassertion, the first request SHALL be acceptable on the next rising edge.

Structure
REQ-044 Package lsu_pkg SHALL hold the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum type.
REQ-045 The lane logic (byte enables, write replication, read shift and extension) SHALL be one combinational sub-module, lsu_lane_align.
REQ-046 The FSM, latches and counter SHALL remain in load_store_unit.

Verification
REQ-047 With a bench memory model holding word 0x8899AABB at address 0x10: lb at 0x11 -> resp_rdata=0xFFFFFFAA; lbu at 0x11 -> 0x000000AA; lh at 0x12 -> 0xFFFF8899; lw at 0x10 -> 0x8899AABB; each with resp_err=0.
REQ-048 Store checks: sb with wdata 0x000000C3 to 0x13 -> data_write_byte=4'b1000 and data_write=0xC3C3C3C3; sh with wdata 0x1234 to 0x12 -> enable 4'b1100; a following lw at 0x10 -> 0x1234AABB.
REQ-049 Error checks: lw at 0x11, sh at 0x13, and funct3=3 -> resp_err=1 and resp_rdata=0 after 1 cycle, with no strobe asserted in any cycle.
REQ-050 Backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stay stable and req_ready stays 0; then resp_ready=1 -> IDLE next cycle.
REQ-051 Reset mid-load: drop reset_n while in WAIT with READ_LATENCY=3 -> strobes are 0 immediately, resp_valid never rises, and the next lw completes normally.
REQ-052 Back-to-back traffic: issue 100 random legal and illegal requests with random resp_ready -> every response matches a reference model and each ACCESS cycle carries exactly one strobe.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared RV32I load/store width codes, FSM state type and request legality helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } lsu_state_e;

   // Misaligned halfword/word, reserved width codes, and unsigned-store codes all fault.
   function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (funct3)
         F3_B, F3_BU: bad = 1'b0;
         F3_H, F3_HU: bad = addr_lo[0];
         F3_W:        bad = (addr_lo != 2'b00);
         default:     bad = 1'b1;
      endcase
      return bad | (we & (funct3 > F3_W));
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store byte enables and replication, load shift and extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wbe_o,
   output logic [31:0] wdat_o,
   output logic [31:0] rdat_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {addr_lo_i, 3'b000};

   always_comb begin
      wbe_o  = 4'b0000;
      wdat_o = wdata_i;
      case (funct3_i)
         F3_B: begin
            wbe_o  = 4'b0001 << addr_lo_i;
            wdat_o = {4{wdata_i[7:0]}};
         end
         F3_H: begin
            wbe_o  = 4'b0011 << {addr_lo_i[1], 1'b0};
            wdat_o = {2{wdata_i[15:0]}};
         end
         F3_W:    wbe_o = 4'b1111;
         default: wbe_o = 4'b0000;
      endcase
   end

   always_comb begin
      rdat_o = 32'h0;
      case (funct3_i)
         F3_B:    rdat_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    rdat_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    rdat_o = shifted;
         F3_BU:   rdat_o = {24'h0, shifted[7:0]};
         F3_HU:   rdat_o = {16'h0, shifted[15:0]};
         default: rdat_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: one strobe cycle per access, fixed-latency read
// return, and a held response until the core takes it.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] data_addr,
   output logic [31:0] data_write,
   output logic [3:0]  data_write_byte,
   output logic        data_read_valid,
   output logic        data_write_valid,
   input  logic [31:0] data_read
);

   localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

   lsu_state_e  state_q;
   logic [1:0]  cnt_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic        ready_q, rvalid_q, err_q, rstb_q, wstb_q;
   logic [31:0] rdata_q, wdat_q;
   logic [3:0]  wbe_q;

   logic        idle;
   logic [2:0]  al_funct3_d;
   logic [1:0]  al_addr_lo_d;
   logic [3:0]  al_wbe_d;
   logic [31:0] al_wdat_d, al_rdat_d;

   // Stores are lane-positioned at acceptance; loads are extracted from the latched request.
   assign idle         = (state_q == IDLE);
   assign al_funct3_d  = idle ? req_funct3    : funct3_q;
   assign al_addr_lo_d = idle ? req_addr[1:0] : addr_q[1:0];

   lsu_lane_align u_lane_align (
      .funct3_i  (al_funct3_d),
      .addr_lo_i (al_addr_lo_d),
      .wdata_i   (req_wdata),
      .rdata_i   (data_read),
      .wbe_o     (al_wbe_d),
      .wdat_o    (al_wdat_d),
      .rdat_o    (al_rdat_d)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'h0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
         rstb_q   <= 1'b0;
         wstb_q   <= 1'b0;
         wbe_q    <= 4'b0000;
         wdat_q   <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  ready_q  <= 1'b0;
                  if (lsu_illegal(req_we, req_funct3, req_addr[1:0])) begin
                     state_q  <= DONE;
                     rvalid_q <= 1'b1;
                     err_q    <= 1'b1;
                     rdata_q  <= 32'h0;
                  end else begin
                     state_q <= ACCESS;
                     rstb_q  <= ~req_we;
                     wstb_q  <= req_we;
                     wbe_q   <= req_we ? al_wbe_d : 4'b0000;
                     wdat_q  <= req_we ? al_wdat_d : 32'h0;
                  end
               end
            end
            ACCESS: begin
               rstb_q <= 1'b0;
               wstb_q <= 1'b0;
               wbe_q  <= 4'b0000;
               wdat_q <= 32'h0;
               cnt_q  <= 2'd0;
               if (we_q) begin
                  state_q  <= DONE;
                  rvalid_q <= 1'b1;
                  err_q    <= 1'b0;
                  rdata_q  <= 32'h0;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == CNT_LAST) begin
                  state_q  <= DONE;
                  cnt_q    <= 2'd0;
                  rvalid_q <= 1'b1;
                  err_q    <= 1'b0;
                  rdata_q  <= al_rdat_d;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state_q  <= IDLE;
                  ready_q  <= 1'b1;
                  rvalid_q <= 1'b0;
                  err_q    <= 1'b0;
                  rdata_q  <= 32'h0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready        = ready_q;
   assign resp_valid       = rvalid_q;
   assign resp_rdata       = rdata_q;
   assign resp_err         = err_q;
   assign data_addr        = addr_q;
   assign data_write       = wdat_q;
   assign data_write_byte  = wbe_q;
   assign data_read_valid  = rstb_q;
   assign data_write_valid = wstb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomised bench for load_store_unit against a byte-level reference memory.
module tb_load_store_unit;

   localparam int RL = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] data_addr, data_write, data_read;
   logic [3:0]  data_write_byte;
   logic        data_read_valid, data_write_valid;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [0:15];
   logic        mem_loaded = 1'b0;
   logic [7:0]  ref_mem [0:63];
   logic [RL-1:0] pv;
   logic [3:0]  pa [RL];
   logic [3:0]  last_be;
   logic [31:0] last_wd;

   always #5 clk = ~clk;

   load_store_unit #(.READ_LATENCY(RL)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_rdata       (resp_rdata),
      .resp_err         (resp_err),
      .data_addr        (data_addr),
      .data_write       (data_write),
      .data_write_byte  (data_write_byte),
      .data_read_valid  (data_read_valid),
      .data_write_valid (data_write_valid),
      .data_read        (data_read)
   );

   function automatic logic [31:0] init_word(input int w);
      if (w == 4) return 32'h8899AABB;
      return 32'(32'h0102_0304 * (w + 1)) ^ 32'h5A00_00A5;
   endfunction

   // Memory with a fixed read pipeline; garbage outside the valid slot exposes mistimed sampling.
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int w = 0; w < 16; w++) mem[w] <= init_word(w);
         mem_loaded <= 1'b1;
      end else if (data_write_valid) begin
         for (int b = 0; b < 4; b++)
            if (data_write_byte[b]) mem[data_addr[5:2]][8*b +: 8] <= data_write[8*b +: 8];
      end
   end

   always @(posedge clk) begin
      if (!reset_n) pv <= '0;
      else pv <= {pv[RL-2:0], data_read_valid};
      pa[0] <= data_addr[5:2];
      for (int i = 1; i < RL; i++) pa[i] <= pa[i-1];
   end

   assign data_read = pv[RL-1] ? mem[pa[RL-1]] : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic ref_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      if (we && f3 > 3'd2) return 1'b1;
      if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
      if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
      int i;
      logic [7:0] b0, b1, b2, b3;
      i  = int'(a[5:0]);
      b0 = ref_mem[i];
      b1 = (i + 1 < 64) ? ref_mem[i+1] : 8'h00;
      b2 = (i + 2 < 64) ? ref_mem[i+2] : 8'h00;
      b3 = (i + 3 < 64) ? ref_mem[i+3] : 8'h00;
      case (f3)
         3'd0:    return {{24{b0[7]}}, b0};
         3'd4:    return {24'h0, b0};
         3'd1:    return {{16{b1[7]}}, b1, b0};
         3'd5:    return {16'h0, b1, b0};
         3'd2:    return {b3, b2, b1, b0};
         default: return 32'h0;
      endcase
   endfunction

   function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int i;
      i = int'(a[5:0]);
      ref_mem[i] = wd[7:0];
      if (f3 != 3'd0) ref_mem[i+1] = wd[15:8];
      if (f3 == 3'd2) begin
         ref_mem[i+2] = wd[23:16];
         ref_mem[i+3] = wd[31:24];
      end
   endfunction

   // Issue one request at a negedge, follow it to its response, then release it after hold cycles.
   task automatic xact(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold);
      logic [31:0] exp_rd;
      logic        exp_err, got_resp;
      int          exp_lat, lat, rstb, wstb;
      exp_err = ref_illegal(we, f3, a);
      exp_rd  = (we || exp_err) ? 32'h0 : ref_load(f3, a);
      exp_lat = exp_err ? 1 : (we ? 2 : 2 + RL);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1; rstb = 0; wstb = 0; got_resp = 1'b0;
      while (!got_resp && lat < 40) begin
         if (data_read_valid) rstb++;
         if (data_write_valid) begin
            wstb++;
            last_be = data_write_byte;
            last_wd = data_write;
         end
         if (resp_valid) got_resp = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_rdata"}, resp_rdata, exp_rd);
      check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
      check({tag, "_rd_strobes"}, 32'(rstb), 32'((!exp_err && !we) ? 1 : 0));
      check({tag, "_wr_strobes"}, 32'(wstb), 32'((!exp_err && we) ? 1 : 0));
      check({tag, "_data_addr"}, data_addr, a);
      if (!exp_err && we) ref_store(f3, a, wd);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
         check({tag, "_hold_rdata"}, resp_rdata, exp_rd);
         check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      int bad;
      logic [31:0] wv;
      for (int w = 0; w < 16; w++) begin
         wv = init_word(w);
         for (int b = 0; b < 4; b++) ref_mem[4*w+b] = wv[8*b +: 8];
      end
      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_data_addr", data_addr, 32'h0);
      check("rst_data_write", data_write, 32'h0);
      check("rst_strobes", {26'h0, data_write_byte, data_read_valid, data_write_valid}, 32'h0);
      reset_n = 1'b1;

      xact("lb_11", 1'b0, 3'd0, 32'h11, 32'h0, 0);
      check("lb_11_value", resp_rdata, 32'h0);
      xact("lbu_11", 1'b0, 3'd4, 32'h11, 32'h0, 0);
      xact("lh_12", 1'b0, 3'd1, 32'h12, 32'h0, 0);
      xact("lhu_12", 1'b0, 3'd5, 32'h12, 32'h0, 0);
      xact("lw_10", 1'b0, 3'd2, 32'h10, 32'h0, 0);
      check("ref_lb_11", ref_load(3'd0, 32'h11), 32'hFFFFFFAA);
      check("ref_lw_10", ref_load(3'd2, 32'h10), 32'h8899AABB);

      xact("sb_13", 1'b1, 3'd0, 32'h13, 32'h0000_00C3, 0);
      check("sb_13_be", 32'(last_be), 32'b1000);
      check("sb_13_wdata", last_wd, 32'hC3C3C3C3);
      xact("sh_12", 1'b1, 3'd1, 32'h12, 32'h0000_1234, 0);
      check("sh_12_be", 32'(last_be), 32'b1100);
      check("sh_12_wdata", last_wd, 32'h12341234);
      xact("lw_10_after", 1'b0, 3'd2, 32'h10, 32'h0, 0);
      check("ref_lw_after", ref_load(3'd2, 32'h10), 32'h1234AABB);
      xact("sw_08", 1'b1, 3'd2, 32'h08, 32'hCAFE_F00D, 0);
      check("sw_08_be", 32'(last_be), 32'b1111);
      xact("lh_0a", 1'b0, 3'd1, 32'h0A, 32'h0, 0);

      xact("err_lw_11", 1'b0, 3'd2, 32'h11, 32'h0, 0);
      xact("err_sh_13", 1'b1, 3'd1, 32'h13, 32'h5555, 0);
      xact("err_f3_3", 1'b0, 3'd3, 32'h10, 32'h0, 0);
      xact("err_sbu", 1'b1, 3'd4, 32'h10, 32'h77, 0);

      xact("bp_lw_10", 1'b0, 3'd2, 32'h10, 32'h0, 5);

      // Reset while the read strobe is up, then again while waiting for read data.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
      @(negedge clk);
      req_valid = 1'b0;
      check("rstacc_strobe_before", 32'(data_read_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rstacc_strobe_after", 32'(data_read_valid), 32'd0);
      check("rstacc_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rstwait_strobes", {30'h0, data_read_valid, data_write_valid}, 32'h0);
      check("rstwait_resp_valid", 32'(resp_valid), 32'd0);
      check("rstwait_data_addr", data_addr, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         if (resp_valid) bad++;
         @(negedge clk);
      end
      check("rstwait_no_resp", 32'(bad), 32'd0);
      xact("post_rst_lw", 1'b0, 3'd2, 32'h10, 32'h0, 0);

      for (int n = 0; n < 100; n++) begin
         xact("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              {26'h0, 6'($urandom_range(0, 63))}, $urandom, $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

endmodule
